// File: rtl/apb_pkg.sv
// apb_pkg: shared APB widths, FSM state encoding and response codes.
package apb_pkg;
    localparam int APB_ADDR_W = 4;
    localparam int APB_DATA_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READY = 2'd2} apb_state_e;
    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;
endpackage

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: NUM_REGS x DATA_W register array, one write port, one combinational read port.
module apb_slave_mem #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) mem_q <= '{default: '0};
        else if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = ({1'b0, raddr_i} < LIMIT) ? mem_q[raddr_i] : '0;
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a small register file, programmable wait states
// and error response for unimplemented addresses.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int NUM_REGS    = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              Pclk,
    input  logic              Presetn,
    input  logic              Psel,
    input  logic              Penable,
    input  logic              Pwrite,
    input  logic [ADDR_W-1:0] Paddr,
    input  logic [DATA_W-1:0] PWdata,
    output logic [DATA_W-1:0] PRdata,
    output logic              Pready,
    output logic              Pslverr
);
    localparam logic [ADDR_W:0] LIMIT    = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [3:0]      CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    apb_state_e        state_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, prdata_q;
    logic              write_q, err_q, pready_q, pslverr_q;
    logic [ADDR_W-1:0] raddr_d;
    logic [DATA_W-1:0] rdata_d, prdata_d;
    logic              setup_err_d, err_d, write_d, we_d;

    // In IDLE the response is built straight from the bus, since hold regs load on the same edge.
    always_comb begin
        setup_err_d = {1'b0, Paddr} >= LIMIT;
        raddr_d     = (state_q == IDLE) ? Paddr : addr_q;
        err_d       = (state_q == IDLE) ? setup_err_d : err_q;
        write_d     = (state_q == IDLE) ? Pwrite : write_q;
        prdata_d    = (err_d || write_d) ? '0 : rdata_d;
        we_d        = (state_q == READY) && Psel && Penable && write_q && !err_q;
    end

    apb_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_mem (
        .clk_i   (Pclk),
        .rst_ni  (Presetn),
        .we_i    (we_d),
        .waddr_i (addr_q),
        .wdata_i (wdata_q),
        .raddr_i (raddr_d),
        .rdata_o (rdata_d)
    );

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (Psel && !Penable) begin
                    addr_q  <= Paddr;
                    wdata_q <= PWdata;
                    write_q <= Pwrite;
                    err_q   <= setup_err_d;
                    if (WAIT_CYCLES == 0) begin
                        state_q   <= READY;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_d ? RESP_SLVERR : RESP_OKAY;
                        prdata_q  <= prdata_d;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                    end
                end
                WAIT: if (!Psel) state_q <= IDLE;
                else if (Penable) begin
                    if (cnt_q == '0) begin
                        state_q   <= READY;
                        pready_q  <= 1'b1;
                        pslverr_q <= err_d ? RESP_SLVERR : RESP_OKAY;
                        prdata_q  <= prdata_d;
                    end else cnt_q <= cnt_q - 4'd1;
                end
                READY: begin
                    state_q   <= IDLE;
                    pready_q  <= 1'b0;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PRdata  = prdata_q;
    assign Pready  = pready_q;
    assign Pslverr = pslverr_q;
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: scoreboard bench driving a zero-wait and a 3-wait instance.
module tb_apb_slave_regfile;
    logic       clk = 1'b0;
    logic       rstn    [2];
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [3:0] paddr   [2];
    logic [7:0] pwdata  [2];
    logic [7:0] prdata  [2];
    logic       pready  [2];
    logic       pslverr [2];

    int cyc = 0, checks = 0, passes = 0;
    logic [7:0] model [2][16];

    typedef struct {logic [7:0] data; logic err; int cyc;} exp_t;
    exp_t q0[$], q1[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        apb_slave_regfile #(.WAIT_CYCLES(g * 3)) u_dut (
            .Pclk    (clk),
            .Presetn (rstn[g]),
            .Psel    (psel[g]),
            .Penable (penable[g]),
            .Pwrite  (pwrite[g]),
            .Paddr   (paddr[g]),
            .PWdata  (pwdata[g]),
            .PRdata  (prdata[g]),
            .Pready  (pready[g]),
            .Pslverr (pslverr[g])
        );
    end

    function automatic int wc(input int d);
        return d == 1 ? 3 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    endtask

    // Monitor: every Pready must match the oldest outstanding expectation; idle bus must read zero.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pready[d]) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    check($sformatf("dut%0d_unexpected_pready", d), 1, 0);
                end else begin
                    mon_e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    check($sformatf("dut%0d_prdata", d), prdata[d], mon_e.data);
                    check($sformatf("dut%0d_pslverr", d), pslverr[d], mon_e.err);
                    check($sformatf("dut%0d_latency", d), cyc, mon_e.cyc);
                end
            end else begin
                check($sformatf("dut%0d_idle_bus", d), {prdata[d], pslverr[d]}, 0);
            end
        end
    end

    task automatic xfer(input int d, input bit wr, input logic [3:0] a, input logic [7:0] wd, input bit abort);
        exp_t e;
        bit err;
        err = (a >= 4'd12);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        e.err = err;
        e.data = (wr || err) ? 8'h00 : model[d][a];
        e.cyc = cyc + 1 + wc(d);
        if (!abort) begin
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            if (wr && !err) model[d][a] = wd;
        end
        @(posedge clk); #1;
        penable[d] = 1'b1;
        paddr[d] = 4'($urandom);
        pwdata[d] = 8'($urandom);
        if (abort) begin
            @(posedge clk); #1;
            psel[d] = 1'b0; penable[d] = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            return;
        end
        for (int i = 0; !pready[d]; i++) begin
            if (i == 20) begin
                check($sformatf("dut%0d_timeout", d), 0, 1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic clear_model(input int d);
        for (int a = 0; a < 16; a++) model[d][a] = 8'h00;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0;
            pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0;
            clear_model(d);
        end
        #1;
        rstn[0] = 1'b0; rstn[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check($sformatf("dut%0d_reset_outputs", d), {prdata[d], pready[d], pslverr[d]}, 0);
        rstn[0] = 1'b1; rstn[1] = 1'b1;
        @(posedge clk); #1;

        xfer(0, 1, 4'h3, 8'hA5, 0);
        xfer(0, 0, 4'h3, 8'h00, 0);
        xfer(1, 1, 4'h7, 8'h5C, 0);
        xfer(1, 0, 4'h7, 8'h00, 0);
        xfer(0, 1, 4'hD, 8'hFF, 0);
        xfer(0, 0, 4'hD, 8'h00, 0);
        for (int a = 0; a < 12; a++) xfer(0, 0, 4'(a), 8'h00, 0);
        for (int a = 0; a < 4; a++) xfer(0, 1, 4'(a), 8'(8'h11 * (a + 1)), 0);
        for (int a = 0; a < 4; a++) xfer(0, 0, 4'(a), 8'h00, 0);

        // Access phase with no setup must be ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 4'h5; pwdata[0] = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        psel[0] = 1'b0; penable[0] = 1'b0;
        xfer(0, 0, 4'h5, 8'h00, 0);

        xfer(1, 1, 4'h2, 8'h99, 1);
        xfer(1, 0, 4'h2, 8'h00, 0);

        xfer(1, 1, 4'h1, 8'h33, 0);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 4'h1; pwdata[1] = 8'h77;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        rstn[1] = 1'b0;
        #1;
        check("dut1_midreset_outputs", {prdata[1], pready[1], pslverr[1]}, 0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        clear_model(1);
        @(posedge clk); #1;
        rstn[1] = 1'b1;
        @(posedge clk); #1;
        xfer(1, 0, 4'h1, 8'h00, 0);

        for (int n = 0; n < 200; n++) begin
            int d;
            bit ab;
            d = int'($urandom_range(0, 1));
            ab = (d == 1) && ($urandom_range(0, 9) == 0);
            xfer(d, 1'($urandom), 4'($urandom_range(0, 15)), 8'($urandom), ab);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (10) @(posedge clk);
        #1;
        check("dut0_drain", q0.size(), 0);
        check("dut1_drain", q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
